// File: rtl/arbitro_contador_2req_pkg.sv
// -----------------------------------------------------------------------------
// arbitro_contador_2req_pkg
// Shared definitions for the two-requester counter arbiter:
//   - NREQ    : number of requesters sharing the counter
//   - state_t : FSM state encoding (IDLE, CLR, RUN, DONE)
//   - onehot  : turns a requester index into a one-hot request-width vector
// -----------------------------------------------------------------------------
package arbitro_contador_2req_pkg;

    localparam int NREQ = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CLR  = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic logic [NREQ-1:0] onehot(input logic idx);
        logic [NREQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/arbitro_contador_2req_contador_habilitado.sv
// -----------------------------------------------------------------------------
// contador_habilitado
// WIDTH-bit synchronous up-counter with synchronous clear and count enable.
// Clear has priority over enable.
// Ports:
//   clk : clock, rising edge
//   en  : count enable, q increments by one per edge while high
//   clr : synchronous clear, forces q to 0 at the next edge
//   q   : current counter value
// -----------------------------------------------------------------------------
module contador_habilitado #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             en,
    input  logic             clr,
    output logic [WIDTH-1:0] q
);

    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= q + WIDTH'(1);
        end
    end

endmodule

// File: rtl/arbitro_contador_2req.sv
// -----------------------------------------------------------------------------
// arbitro_contador_2req
// Round-robin arbiter and controller that lends one shared up-counter to two
// requesters. The winner gets the counter cleared, counts up to its requested
// duration, then receives a one-cycle done pulse.
// Ports:
//   clk   : clock, rising edge
//   clear : synchronous active-high reset
//   req   : request per requester; must stay high until done or it aborts
//   dur0  : interval length for requester 0, sampled at grant
//   dur1  : interval length for requester 1, sampled at grant
//   gnt   : one-hot grant, 00 when idle
//   done  : one-cycle completion pulse to the granted requester
//   busy  : high whenever the FSM is not idle
//   count : live value of the shared counter
// -----------------------------------------------------------------------------
module arbitro_contador_2req
    import arbitro_contador_2req_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             clear,
    input  logic [NREQ-1:0]  req,
    input  logic [WIDTH-1:0] dur0,
    input  logic [WIDTH-1:0] dur1,
    output logic [NREQ-1:0]  gnt,
    output logic [NREQ-1:0]  done,
    output logic             busy,
    output logic [WIDTH-1:0] count
);

    state_t           state, state_next;
    logic             g, g_next;          // index of the current winner
    logic             last, last_next;    // most recently served requester
    logic [WIDTH-1:0] dur_reg, dur_next;
    logic [WIDTH:0]   count_inc;          // one bit wider so the compare never wraps

    assign count_inc = {1'b0, count} + (WIDTH+1)'(1);

    // The arbiter is the sole owner of the counter controls.
    contador_habilitado #(.WIDTH(WIDTH)) u_contador (
        .clk (clk),
        .en  (state == RUN),
        .clr (clear | (state == CLR)),
        .q   (count)
    );

    always_ff @(posedge clk) begin
        if (clear) begin
            state   <= IDLE;
            g       <= 1'b0;
            last    <= 1'b1;              // requester 0 wins the first tie
            dur_reg <= '0;
        end else begin
            state   <= state_next;
            g       <= g_next;
            last    <= last_next;
            dur_reg <= dur_next;
        end
    end

    always_comb begin
        // NOTE: every variable gets its hold value first so no path through
        // the case statement leaves one unassigned and infers a latch.
        state_next = state;
        g_next     = g;
        last_next  = last;
        dur_next   = dur_reg;

        unique case (state)
            IDLE: begin
                if (req != '0) begin
                    // On a tie the requester not served last wins; otherwise
                    // req[1] alone identifies the single requester.
                    g_next     = (req == 2'b11) ? ~last : req[1];
                    dur_next   = g_next ? dur1 : dur0;
                    state_next = CLR;
                end
            end
            CLR: begin
                if (!req[g]) begin
                    state_next = IDLE;
                    last_next  = g;
                end else begin
                    state_next = (dur_reg != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                // Abort wins over completion: a dropped request never gets done.
                if (!req[g]) begin
                    state_next = IDLE;
                    last_next  = g;
                end else if (count_inc == {1'b0, dur_reg}) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
                last_next  = g;
            end
            default: state_next = IDLE;
        endcase
    end

    // Moore outputs decoded from registered state and winner.
    assign busy = (state != IDLE);
    assign gnt  = busy            ? onehot(g) : '0;
    assign done = (state == DONE) ? onehot(g) : '0;

endmodule

// File: tb/tb_arbitro_contador_2req.sv
// -----------------------------------------------------------------------------
// tb_arbitro_contador_2req
// Directed self-checking bench for arbitro_contador_2req (WIDTH=4).
// Inputs change 1 time unit after each rising edge; outputs are checked at
// the same point, after they have settled from that edge.
// -----------------------------------------------------------------------------
module tb_arbitro_contador_2req;

    logic       clk;
    logic       clear;
    logic [1:0] req;
    logic [3:0] dur0;
    logic [3:0] dur1;
    logic [1:0] gnt;
    logic [1:0] done;
    logic       busy;
    logic [3:0] count;

    int passes = 0;
    int fails  = 0;
    int total  = 0;

    arbitro_contador_2req #(.WIDTH(4)) dut (
        .clk   (clk),
        .clear (clear),
        .req   (req),
        .dur0  (dur0),
        .dur1  (dur1),
        .gnt   (gnt),
        .done  (done),
        .busy  (busy),
        .count (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [1:0] e_gnt,
                              input logic [1:0] e_done, input logic e_busy,
                              input logic [3:0] e_count);
        check({tag, "_gnt"},   32'(gnt),   32'(e_gnt));
        check({tag, "_done"},  32'(done),  32'(e_done));
        check({tag, "_busy"},  32'(busy),  32'(e_busy));
        check({tag, "_count"}, 32'(count), 32'(e_count));
    endtask

    initial begin
        clear = 1'b1;
        req   = 2'b00;
        dur0  = 4'd0;
        dur1  = 4'd0;

        // ---------------- reset then idle ----------------
        step();
        step();
        clear = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            expect_out("idle", 2'b00, 2'b00, 1'b0, 4'd0);
        end

        // ---------------- single request, dur0=3 ----------------
        req  = 2'b01;
        dur0 = 4'd3;
        step();                                   // edge k: grant
        dur0 = 4'd9;                              // must not affect the interval
        expect_out("single_clr", 2'b01, 2'b00, 1'b1, 4'd0);
        step();
        expect_out("single_c0", 2'b01, 2'b00, 1'b1, 4'd0);
        step();
        expect_out("single_c1", 2'b01, 2'b00, 1'b1, 4'd1);
        step();
        expect_out("single_c2", 2'b01, 2'b00, 1'b1, 4'd2);
        step();                                   // edge k+4
        expect_out("single_done", 2'b01, 2'b01, 1'b1, 4'd3);
        req = 2'b00;
        step();
        expect_out("single_idle", 2'b00, 2'b00, 1'b0, 4'd3);

        // ---------------- zero duration on requester 1 ----------------
        req  = 2'b10;
        dur1 = 4'd0;
        step();
        expect_out("zero_clr", 2'b10, 2'b00, 1'b1, 4'd3);
        step();
        expect_out("zero_done", 2'b10, 2'b10, 1'b1, 4'd0);
        req = 2'b00;
        step();
        expect_out("zero_idle", 2'b00, 2'b00, 1'b0, 4'd0);

        // ---------------- contention, req=11 held ----------------
        // Requester 1 was served last, so requester 0 wins first.
        req  = 2'b11;
        dur0 = 4'd2;
        dur1 = 4'd1;
        step();
        expect_out("cont0_clr", 2'b01, 2'b00, 1'b1, 4'd0);
        step();
        expect_out("cont0_c0", 2'b01, 2'b00, 1'b1, 4'd0);
        step();
        expect_out("cont0_c1", 2'b01, 2'b00, 1'b1, 4'd1);
        step();
        expect_out("cont0_done", 2'b01, 2'b01, 1'b1, 4'd2);
        step();
        expect_out("cont0_idle", 2'b00, 2'b00, 1'b0, 4'd2);
        step();
        expect_out("cont1_clr", 2'b10, 2'b00, 1'b1, 4'd2);
        step();
        expect_out("cont1_c0", 2'b10, 2'b00, 1'b1, 4'd0);
        step();
        expect_out("cont1_done", 2'b10, 2'b10, 1'b1, 4'd1);
        step();
        expect_out("cont1_idle", 2'b00, 2'b00, 1'b0, 4'd1);
        step();
        expect_out("cont2_clr", 2'b01, 2'b00, 1'b1, 4'd1);
        // Drop both requests in CLR: abort, counter still cleared this edge.
        req = 2'b00;
        step();
        expect_out("cont2_abort", 2'b00, 2'b00, 1'b0, 4'd0);

        // ---------------- max duration, dur0=15 ----------------
        req  = 2'b01;
        dur0 = 4'd15;
        step();
        expect_out("max_clr", 2'b01, 2'b00, 1'b1, 4'd0);
        step();
        expect_out("max_c0", 2'b01, 2'b00, 1'b1, 4'd0);
        for (int i = 1; i < 15; i++) begin
            step();
            expect_out("max_run", 2'b01, 2'b00, 1'b1, 4'(i));
        end
        step();
        expect_out("max_done", 2'b01, 2'b01, 1'b1, 4'd15);
        req = 2'b00;
        step();
        expect_out("max_idle", 2'b00, 2'b00, 1'b0, 4'd15);
        step();
        expect_out("max_nowrap", 2'b00, 2'b00, 1'b0, 4'd15);

        // ---------------- abort in RUN, dur0=8 ----------------
        req  = 2'b01;
        dur0 = 4'd8;
        step();
        dur0 = 4'd2;                              // sampled value stays 8
        expect_out("abort_clr", 2'b01, 2'b00, 1'b1, 4'd15);
        step();
        expect_out("abort_c0", 2'b01, 2'b00, 1'b1, 4'd0);
        for (int i = 1; i <= 4; i++) begin
            step();
            expect_out("abort_run", 2'b01, 2'b00, 1'b1, 4'(i));
        end
        req = 2'b00;                              // drop while count=4
        step();                                   // still RUN at this edge: +1
        expect_out("abort_idle", 2'b00, 2'b00, 1'b0, 4'd5);
        step();
        expect_out("abort_frozen", 2'b00, 2'b00, 1'b0, 4'd5);

        // ---------------- reset mid-run ----------------
        // Requester 0 was served last; only clear can make it win a tie now.
        req  = 2'b01;
        dur0 = 4'd10;
        step();
        expect_out("rst_clr", 2'b01, 2'b00, 1'b1, 4'd5);
        step();
        expect_out("rst_c0", 2'b01, 2'b00, 1'b1, 4'd0);
        for (int i = 1; i <= 6; i++) begin
            step();
            expect_out("rst_run", 2'b01, 2'b00, 1'b1, 4'(i));
        end
        clear = 1'b1;
        step();
        expect_out("rst_after", 2'b00, 2'b00, 1'b0, 4'd0);
        clear = 1'b0;
        req   = 2'b11;
        dur0  = 4'd1;
        dur1  = 4'd1;
        step();
        expect_out("rst_tie", 2'b01, 2'b00, 1'b1, 4'd0);
        req = 2'b00;
        step();
        expect_out("rst_end", 2'b00, 2'b00, 1'b0, 4'd0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule

// File: doc/arbitro_contador_2req.md
Name: arbitro_contador_2req

Overview:
- Controller and round-robin arbiter that shares one WIDTH-bit synchronous up-counter between two requesters.
- Each requester asks for a timed interval of dur cycles.
- The block grants the counter, clears it, enables counting until count equals dur, then pulses done to the winner.
- Sits between bus-side requesters and the shared counter datapath; it is the only driver of the counter's enable and clear.

Parameters:
- WIDTH, 4, bit width of counter, dur0, dur1 and count.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- clear  input  1  synchronous, active-high reset.
- req  input  2  req[i] high = requester i wants the counter; must be held until done[i] or it is treated as an abort.
- dur0  input  WIDTH  interval length for requester 0; sampled only at grant.
- dur1  input  WIDTH  interval length for requester 1; sampled only at grant.
- gnt  output  2  one-hot grant, registered; 00 when idle.
- done  output  2  one-cycle completion pulse to the granted requester, registered.
- busy  output  1  high whenever state != IDLE.
- count  output  WIDTH  live value of the shared counter.

Behaviour:
- Reset (clear=1 at an edge), from any state including mid-interval:
  - state=IDLE, gnt=00, done=00, busy=0, count=0.
  - Round-robin pointer last=1, so requester 0 wins the first tie.
  - No done pulse is issued for an interrupted interval.
- FSM states: IDLE, CLR, RUN, DONE. Moore outputs: gnt/done/busy decoded from registered state plus the registered winner index g.
- IDLE:
  - req=00: stay.
  - Exactly one req bit set: that requester wins.
  - req=11: the requester != last wins.
  - At the edge: latch g, latch dur_reg from dur0/dur1, gnt[g]=1, go to CLR.
- CLR:
  - Counter cleared (count=0 after the edge).
  - Next state is RUN if dur_reg!=0, else DONE.
  - Abort rule applies.
- RUN:
  - Counter enable=1; count increments by 1 per edge.
  - At the edge where count+1==dur_reg: count becomes dur_reg and state becomes DONE.
  - Abort rule applies.
- DONE:
  - done[g]=1 for exactly this cycle; gnt[g] still 1; count holds.
  - Next edge: IDLE, gnt=00, last=g, count holds until the next CLR.
  - req sampled during DONE is ignored; arbitration only happens in IDLE.
- Abort: if req[g]=0 while in CLR or RUN:
  - Next edge goes to IDLE with no done pulse, gnt=00, last=g.
  - count freezes at its current value.
- Latency, with winner sampled in IDLE at edge k:
  - gnt visible after edge k.
  - done visible in the cycle after edge k+1+dur (dur=0 gives done one cycle after the CLR cycle).
  - Back-to-back grants are spaced by at least one IDLE cycle.
- Width rules: dur in 0..2^WIDTH-1; count never exceeds dur_reg, so there is no wrap-around. The counter enable is gated off in every state except RUN.
- Inputs dur0/dur1 may change freely after grant; only dur_reg is used.

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE=2'd0, CLR=2'd1, RUN=2'd2, DONE=2'd3);
  - the requester count constant NREQ=2.
- One natural sub-module, contador_habilitado: WIDTH-bit synchronous up-counter with ports clk, en, clr, q.
  - clr is synchronous and takes priority over en.
  - Driven by this block with en = (state==RUN) and clr = clear | (state==CLR).

Test Plan:
- Reset then idle: clear=1 for 2 cycles, req=00 -> gnt=00, done=00, busy=0, count=0 for 5 cycles.
- Single request: req=01, dur0=3 -> gnt=01 after edge k; count goes 0,1,2,3; done=01 for exactly one cycle after edge k+4; then gnt=00.
- Contention and fairness: req=11, dur0=2, dur1=1, both held until their own done:
  - first grant goes to requester 0; after its done, requester 1 is granted;
  - with req=11 held continuously, grants alternate 01,10,01.
- Zero and max duration:
  - dur1=0 -> done=10 one cycle after CLR, count=0.
  - dur0=15 -> count reaches 15, done=01, no wrap.
- Abort: req=01, dur0=8, drop req[0] when count=4 -> next edge IDLE, done never asserted, count frozen at 4 or 5 per the edge timing.
- Reset mid-run: clear=1 while RUN with count=6 -> after the edge state IDLE, count=0, gnt=00, no done pulse; a subsequent req=11 grants requester 0.
